// File: rtl/core_bus_arbiter.sv
// core_bus_arbiter: merges the core's instruction-fetch port and data port onto
// one shared single-port memory bus (cyc/ack handshake). Requests are served one
// at a time with round-robin priority on contention. Read data is returned to the
// owning port, and a transfer is aborted if the slave never acks.
module core_bus_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  im_req_i,
    input  logic [ADDR_WIDTH-1:0] im_addr_i,
    output logic [DATA_WIDTH-1:0] im_rdata_o,
    output logic                  im_ack_o,
    input  logic                  dm_req_i,
    input  logic                  dm_we_i,
    input  logic [ADDR_WIDTH-1:0] dm_addr_i,
    input  logic [DATA_WIDTH-1:0] dm_wdata_i,
    output logic [DATA_WIDTH-1:0] dm_rdata_o,
    output logic                  dm_ack_o,
    output logic                  stall_req_o,
    output logic                  bus_cyc_o,
    output logic                  bus_we_o,
    output logic [ADDR_WIDTH-1:0] bus_addr_o,
    output logic [DATA_WIDTH-1:0] bus_wdata_o,
    input  logic [DATA_WIDTH-1:0] bus_rdata_i,
    input  logic                  bus_ack_i,
    output logic                  bus_err_o
);

    // Counter only needs to reach TIMEOUT-1.
    localparam int unsigned      CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE,
        D_BUSY,
        I_BUSY
    } state_t;

    typedef enum logic {
        GRANT_INST,
        GRANT_DATA
    } grant_t;

    state_t                 state;
    grant_t                 last_grant;
    logic [CNT_W-1:0]       cnt;

    logic                   grant_data;
    logic                   timed_out;
    logic                   finish;
    logic [DATA_WIDTH-1:0]  xfer_rdata;

    // Grant selection and completion detection for the current cycle.
    always_comb begin
        grant_data = dm_req_i & (~im_req_i | (last_grant == GRANT_INST));
        timed_out  = (TIMEOUT != 0) && (cnt == CNT_LAST);
        finish     = bus_ack_i | timed_out;
        xfer_rdata = bus_ack_i ? bus_rdata_i : '0;
    end

    // Stall the pipeline while any requester is waiting for its ack.
    always_comb begin
        stall_req_o = (dm_req_i & ~dm_ack_o) | (im_req_i & ~im_ack_o);
    end

    // Arbitration FSM with registered bus and completion outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            last_grant  <= GRANT_INST;
            cnt         <= '0;
            im_rdata_o  <= '0;
            im_ack_o    <= 1'b0;
            dm_rdata_o  <= '0;
            dm_ack_o    <= 1'b0;
            bus_cyc_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            bus_err_o   <= 1'b0;
        end else begin
            im_ack_o  <= 1'b0;
            dm_ack_o  <= 1'b0;
            bus_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    // The ack cycle is spent idle so the finishing requester
                    // cannot be re-granted on its still-asserted request.
                    if (!im_ack_o && !dm_ack_o && (im_req_i || dm_req_i)) begin
                        bus_cyc_o <= 1'b1;
                        cnt       <= '0;
                        if (grant_data) begin
                            bus_we_o    <= dm_we_i;
                            bus_addr_o  <= dm_addr_i;
                            bus_wdata_o <= dm_wdata_i;
                            last_grant  <= GRANT_DATA;
                            state       <= D_BUSY;
                        end else begin
                            bus_we_o    <= 1'b0;
                            bus_addr_o  <= im_addr_i;
                            bus_wdata_o <= '0;
                            last_grant  <= GRANT_INST;
                            state       <= I_BUSY;
                        end
                    end
                end
                D_BUSY, I_BUSY: begin
                    if (finish) begin
                        bus_cyc_o <= 1'b0;
                        bus_err_o <= ~bus_ack_i;
                        cnt       <= '0;
                        state     <= IDLE;
                        if (state == D_BUSY) begin
                            dm_ack_o   <= 1'b1;
                            dm_rdata_o <= bus_we_o ? '0 : xfer_rdata;
                        end else begin
                            im_ack_o   <= 1'b1;
                            im_rdata_o <= xfer_rdata;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Bench for core_bus_arbiter: directed per-cycle vector table covering the
// main scenarios, followed by randomized traffic against a transaction model.
module tb_core_bus_arbiter;

    localparam int unsigned TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        im_req_i;
    logic [31:0] im_addr_i;
    logic [31:0] im_rdata_o;
    logic        im_ack_o;
    logic        dm_req_i;
    logic        dm_we_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_wdata_i;
    logic [31:0] dm_rdata_o;
    logic        dm_ack_o;
    logic        stall_req_o;
    logic        bus_cyc_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;
    logic        bus_err_o;

    int checks = 0;
    int errors = 0;

    core_bus_arbiter #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT(TO)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .im_req_i(im_req_i),
        .im_addr_i(im_addr_i),
        .im_rdata_o(im_rdata_o),
        .im_ack_o(im_ack_o),
        .dm_req_i(dm_req_i),
        .dm_we_i(dm_we_i),
        .dm_addr_i(dm_addr_i),
        .dm_wdata_i(dm_wdata_i),
        .dm_rdata_o(dm_rdata_o),
        .dm_ack_o(dm_ack_o),
        .stall_req_o(stall_req_o),
        .bus_cyc_o(bus_cyc_o),
        .bus_we_o(bus_we_o),
        .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o),
        .bus_rdata_i(bus_rdata_i),
        .bus_ack_i(bus_ack_i),
        .bus_err_o(bus_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // One row = one clock cycle: inputs present and outputs expected during it.
    typedef struct {
        logic        rst, imr;
        logic [31:0] ima;
        logic        dmr, dwe;
        logic [31:0] dma, dwd;
        logic        ack;
        logic [31:0] rd;
        logic        chk, all;
        logic        cyc, bwe;
        logic [31:0] badr, bwd;
        logic        iack;
        logic [31:0] ird;
        logic        dack;
        logic [31:0] drd;
        logic        err, stall;
    } vec_t;

    vec_t vecs[$];

    task automatic row(
        input logic rst, input logic imr, input logic [31:0] ima,
        input logic dmr, input logic dwe, input logic [31:0] dma, input logic [31:0] dwd,
        input logic ack, input logic [31:0] rd, input logic chk, input logic all,
        input logic cyc, input logic bwe, input logic [31:0] badr, input logic [31:0] bwd,
        input logic iack, input logic [31:0] ird, input logic dack, input logic [31:0] drd,
        input logic err, input logic stall);
        vec_t v;
        v.rst = rst; v.imr = imr; v.ima = ima; v.dmr = dmr; v.dwe = dwe;
        v.dma = dma; v.dwd = dwd; v.ack = ack; v.rd = rd; v.chk = chk; v.all = all;
        v.cyc = cyc; v.bwe = bwe; v.badr = badr; v.bwd = bwd; v.iack = iack;
        v.ird = ird; v.dack = dack; v.drd = drd; v.err = err; v.stall = stall;
        vecs.push_back(v);
    endtask

    // Transaction-level reference model state.
    logic        m_busy, m_data, m_last_data, m_we;
    int          m_waited;
    logic [31:0] m_addr, m_wdata, m_im_rdata, m_dm_rdata;
    logic        m_im_ack, m_dm_ack, m_err;

    task automatic model_step();
        logic ack_cycle;
        ack_cycle = m_im_ack | m_dm_ack;
        if (rst_i) begin
            m_busy = 0; m_data = 0; m_last_data = 0; m_we = 0; m_waited = 0;
            m_addr = 0; m_wdata = 0; m_im_rdata = 0; m_dm_rdata = 0;
            m_im_ack = 0; m_dm_ack = 0; m_err = 0;
        end else begin
            m_im_ack = 0; m_dm_ack = 0; m_err = 0;
            if (m_busy) begin
                m_waited++;
                if (bus_ack_i || m_waited == int'(TO)) begin
                    m_busy = 0;
                    m_err  = !bus_ack_i;
                    if (m_data) begin
                        m_dm_ack   = 1;
                        m_dm_rdata = (m_we || !bus_ack_i) ? 32'h0 : bus_rdata_i;
                    end else begin
                        m_im_ack   = 1;
                        m_im_rdata = bus_ack_i ? bus_rdata_i : 32'h0;
                    end
                end
            end else if (!ack_cycle && (im_req_i || dm_req_i)) begin
                // Contention goes to whichever port did not win last time.
                m_data      = dm_req_i && !(im_req_i && m_last_data);
                m_last_data = m_data;
                m_busy      = 1;
                m_waited    = 0;
                m_we        = m_data ? dm_we_i : 1'b0;
                m_addr      = m_data ? dm_addr_i : im_addr_i;
                m_wdata     = m_data ? dm_wdata_i : 32'h0;
            end
        end
    endtask

    initial begin
        rst_i = 1; im_req_i = 0; im_addr_i = 0; dm_req_i = 0; dm_we_i = 0;
        dm_addr_i = 0; dm_wdata_i = 0; bus_ack_i = 0; bus_rdata_i = 0;

        //  rst imr ima         dmr dwe dma          dwd           ack rd            chk all cyc bwe badr         bwd           iack ird           dack drd           err stall
        // Lone fetch, two wait states
        row(1, 0, 32'h0,     0, 0, 32'h0,     32'h0,        0, 32'h0,        0, 0, 0, 0, 32'h0,     32'h0,        0, 32'h0,        0, 32'h0,        0, 0);
        row(0, 1, 32'h100,   0, 0, 32'h0,     32'h0,        0, 32'h0,        1, 1, 0, 0, 32'h0,     32'h0,        0, 32'h0,        0, 32'h0,        0, 1);
        row(0, 1, 32'h100,   0, 0, 32'h0,     32'h0,        0, 32'h0,        1, 0, 1, 0, 32'h100,   32'h0,        0, 32'h0,        0, 32'h0,        0, 1);
        row(0, 1, 32'h100,   0, 0, 32'h0,     32'h0,        0, 32'h0,        1, 0, 1, 0, 32'h100,   32'h0,        0, 32'h0,        0, 32'h0,        0, 1);
        row(0, 1, 32'h100,   0, 0, 32'h0,     32'h0,        1, 32'h13,       1, 0, 1, 0, 32'h100,   32'h0,        0, 32'h0,        0, 32'h0,        0, 1);
        row(0, 1, 32'h100,   0, 0, 32'h0,     32'h0,        0, 32'h0,        1, 0, 0, 0, 32'h0,     32'h0,        1, 32'h13,       0, 32'h0,        0, 0);
        row(0, 0, 32'h0,     0, 0, 32'h0,     32'h0,        0, 32'h0,        1, 0, 0, 0, 32'h0,     32'h0,        0, 32'h0,        0, 32'h0,        0, 0);
        // Store, zero-wait slave
        row(0, 0, 32'h0,     1, 1, 32'h2000,  32'hDEADBEEF, 0, 32'h0,        1, 0, 0, 0, 32'h0,     32'h0,        0, 32'h0,        0, 32'h0,        0, 1);
        row(0, 0, 32'h0,     1, 1, 32'h2000,  32'hDEADBEEF, 1, 32'h55,       1, 0, 1, 1, 32'h2000,  32'hDEADBEEF, 0, 32'h0,        0, 32'h0,        0, 1);
        row(0, 0, 32'h0,     1, 1, 32'h2000,  32'hDEADBEEF, 0, 32'h0,        1, 0, 0, 0, 32'h0,     32'h0,        0, 32'h0,        1, 32'h0,        0, 0);
        row(0, 0, 32'h0,     0, 0, 32'h0,     32'h0,        0, 32'h0,        1, 0, 0, 0, 32'h0,     32'h0,        0, 32'h0,        0, 32'h0,        0, 0);
        // Contention after reset: D, I, D, I
        row(1, 0, 32'h0,     0, 0, 32'h0,     32'h0,        0, 32'h0,        0, 0, 0, 0, 32'h0,     32'h0,        0, 32'h0,        0, 32'h0,        0, 0);
        row(0, 1, 32'h104,   1, 0, 32'h3000,  32'h0,        0, 32'h0,        1, 1, 0, 0, 32'h0,     32'h0,        0, 32'h0,        0, 32'h0,        0, 1);
        row(0, 1, 32'h104,   1, 0, 32'h3000,  32'h0,        1, 32'hAAAA0001, 1, 0, 1, 0, 32'h3000,  32'h0,        0, 32'h0,        0, 32'h0,        0, 1);
        row(0, 1, 32'h104,   1, 0, 32'h3000,  32'h0,        0, 32'h0,        1, 0, 0, 0, 32'h0,     32'h0,        0, 32'h0,        1, 32'hAAAA0001, 0, 1);
        row(0, 1, 32'h104,   1, 0, 32'h3004,  32'h0,        0, 32'h0,        1, 0, 0, 0, 32'h0,     32'h0,        0, 32'h0,        0, 32'h0,        0, 1);
        row(0, 1, 32'h104,   1, 0, 32'h3004,  32'h0,        1, 32'hBBBB0002, 1, 0, 1, 0, 32'h104,   32'h0,        0, 32'h0,        0, 32'h0,        0, 1);
        row(0, 1, 32'h104,   1, 0, 32'h3004,  32'h0,        0, 32'h0,        1, 0, 0, 0, 32'h0,     32'h0,        1, 32'hBBBB0002, 0, 32'h0,        0, 1);
        row(0, 1, 32'h108,   1, 0, 32'h3004,  32'h0,        0, 32'h0,        1, 0, 0, 0, 32'h0,     32'h0,        0, 32'h0,        0, 32'h0,        0, 1);
        row(0, 1, 32'h108,   1, 0, 32'h3004,  32'h0,        1, 32'hCCCC0003, 1, 0, 1, 0, 32'h3004,  32'h0,        0, 32'h0,        0, 32'h0,        0, 1);
        row(0, 1, 32'h108,   1, 0, 32'h3004,  32'h0,        0, 32'h0,        1, 0, 0, 0, 32'h0,     32'h0,        0, 32'h0,        1, 32'hCCCC0003, 0, 1);
        row(0, 1, 32'h108,   0, 0, 32'h0,     32'h0,        0, 32'h0,        1, 0, 0, 0, 32'h0,     32'h0,        0, 32'h0,        0, 32'h0,        0, 1);
        row(0, 1, 32'h108,   0, 0, 32'h0,     32'h0,        1, 32'hDDDD0004, 1, 0, 1, 0, 32'h108,   32'h0,        0, 32'h0,        0, 32'h0,        0, 1);
        row(0, 1, 32'h108,   0, 0, 32'h0,     32'h0,        0, 32'h0,        1, 0, 0, 0, 32'h0,     32'h0,        1, 32'hDDDD0004, 0, 32'h0,        0, 0);
        row(0, 0, 32'h0,     0, 0, 32'h0,     32'h0,        0, 32'h0,        1, 0, 0, 0, 32'h0,     32'h0,        0, 32'h0,        0, 32'h0,        0, 0);
        // Timeout: slave never acks, TIMEOUT=4
        row(0, 0, 32'h0,     1, 0, 32'h4000,  32'h0,        0, 32'h0,        1, 0, 0, 0, 32'h0,     32'h0,        0, 32'h0,        0, 32'h0,        0, 1);
        row(0, 0, 32'h0,     1, 0, 32'h4000,  32'h0,        0, 32'h0,        1, 0, 1, 0, 32'h4000,  32'h0,        0, 32'h0,        0, 32'h0,        0, 1);
        row(0, 0, 32'h0,     1, 0, 32'h4000,  32'h0,        0, 32'h0,        1, 0, 1, 0, 32'h4000,  32'h0,        0, 32'h0,        0, 32'h0,        0, 1);
        row(0, 0, 32'h0,     1, 0, 32'h4000,  32'h0,        0, 32'h0,        1, 0, 1, 0, 32'h4000,  32'h0,        0, 32'h0,        0, 32'h0,        0, 1);
        row(0, 0, 32'h0,     1, 0, 32'h4000,  32'h0,        0, 32'h0,        1, 0, 1, 0, 32'h4000,  32'h0,        0, 32'h0,        0, 32'h0,        0, 1);
        row(0, 0, 32'h0,     1, 0, 32'h4000,  32'h0,        0, 32'h0,        1, 0, 0, 0, 32'h0,     32'h0,        0, 32'h0,        1, 32'h0,        1, 0);
        row(0, 0, 32'h0,     0, 0, 32'h0,     32'h0,        0, 32'h0,        1, 0, 0, 0, 32'h0,     32'h0,        0, 32'h0,        0, 32'h0,        0, 0);
        // Reset in the second busy cycle, late slave ack ignored
        row(0, 1, 32'h200,   0, 0, 32'h0,     32'h0,        0, 32'h0,        1, 0, 0, 0, 32'h0,     32'h0,        0, 32'h0,        0, 32'h0,        0, 1);
        row(0, 1, 32'h200,   0, 0, 32'h0,     32'h0,        0, 32'h0,        1, 0, 1, 0, 32'h200,   32'h0,        0, 32'h0,        0, 32'h0,        0, 1);
        row(1, 1, 32'h200,   0, 0, 32'h0,     32'h0,        0, 32'h0,        1, 0, 1, 0, 32'h200,   32'h0,        0, 32'h0,        0, 32'h0,        0, 1);
        row(0, 0, 32'h0,     0, 0, 32'h0,     32'h0,        1, 32'h99,       1, 1, 0, 0, 32'h0,     32'h0,        0, 32'h0,        0, 32'h0,        0, 0);
        row(0, 0, 32'h0,     0, 0, 32'h0,     32'h0,        0, 32'h0,        1, 0, 0, 0, 32'h0,     32'h0,        0, 32'h0,        0, 32'h0,        0, 0);
        // Fetch withdrawn while busy still completes
        row(0, 1, 32'h300,   0, 0, 32'h0,     32'h0,        0, 32'h0,        1, 0, 0, 0, 32'h0,     32'h0,        0, 32'h0,        0, 32'h0,        0, 1);
        row(0, 1, 32'h300,   0, 0, 32'h0,     32'h0,        0, 32'h0,        1, 0, 1, 0, 32'h300,   32'h0,        0, 32'h0,        0, 32'h0,        0, 1);
        row(0, 0, 32'h300,   0, 0, 32'h0,     32'h0,        0, 32'h0,        1, 0, 1, 0, 32'h300,   32'h0,        0, 32'h0,        0, 32'h0,        0, 0);
        row(0, 0, 32'h300,   0, 0, 32'h0,     32'h0,        1, 32'h77,       1, 0, 1, 0, 32'h300,   32'h0,        0, 32'h0,        0, 32'h0,        0, 0);
        row(0, 0, 32'h0,     0, 0, 32'h0,     32'h0,        0, 32'h0,        1, 0, 0, 0, 32'h0,     32'h0,        1, 32'h77,       0, 32'h0,        0, 0);
        row(0, 0, 32'h0,     0, 0, 32'h0,     32'h0,        0, 32'h0,        1, 0, 0, 0, 32'h0,     32'h0,        0, 32'h0,        0, 32'h0,        0, 0);

        for (int k = 0; k < vecs.size(); k++) begin
            vec_t v;
            v = vecs[k];
            @(negedge clk_i);
            rst_i = v.rst; im_req_i = v.imr; im_addr_i = v.ima; dm_req_i = v.dmr;
            dm_we_i = v.dwe; dm_addr_i = v.dma; dm_wdata_i = v.dwd;
            bus_ack_i = v.ack; bus_rdata_i = v.rd;
            #1;
            if (v.chk) begin
                check($sformatf("r%0d_cyc", k),   {31'h0, bus_cyc_o},   {31'h0, v.cyc});
                check($sformatf("r%0d_iack", k),  {31'h0, im_ack_o},    {31'h0, v.iack});
                check($sformatf("r%0d_dack", k),  {31'h0, dm_ack_o},    {31'h0, v.dack});
                check($sformatf("r%0d_err", k),   {31'h0, bus_err_o},   {31'h0, v.err});
                check($sformatf("r%0d_stall", k), {31'h0, stall_req_o}, {31'h0, v.stall});
                if (v.cyc || v.all) begin
                    check($sformatf("r%0d_we", k),    {31'h0, bus_we_o}, {31'h0, v.bwe});
                    check($sformatf("r%0d_addr", k),  bus_addr_o,  v.badr);
                    check($sformatf("r%0d_wdata", k), bus_wdata_o, v.bwd);
                end
                if (v.iack || v.all) check($sformatf("r%0d_ird", k), im_rdata_o, v.ird);
                if (v.dack || v.all) check($sformatf("r%0d_drd", k), dm_rdata_o, v.drd);
            end
        end

        // Randomized traffic against the reference model
        rst_i = 1; im_req_i = 0; dm_req_i = 0; bus_ack_i = 0;
        @(posedge clk_i);
        model_step();
        repeat (3000) begin
            @(negedge clk_i);
            check("rnd_cyc",   {31'h0, bus_cyc_o}, {31'h0, m_busy});
            check("rnd_iack",  {31'h0, im_ack_o},  {31'h0, m_im_ack});
            check("rnd_dack",  {31'h0, dm_ack_o},  {31'h0, m_dm_ack});
            check("rnd_err",   {31'h0, bus_err_o}, {31'h0, m_err});
            check("rnd_stall", {31'h0, stall_req_o},
                  {31'h0, (dm_req_i & ~m_dm_ack) | (im_req_i & ~m_im_ack)});
            check("rnd_one_ack", {31'h0, im_ack_o & dm_ack_o}, 32'h0);
            if (m_busy) begin
                check("rnd_we",    {31'h0, bus_we_o}, {31'h0, m_we});
                check("rnd_addr",  bus_addr_o,  m_addr);
                check("rnd_wdata", bus_wdata_o, m_wdata);
            end
            if (m_im_ack) check("rnd_ird", im_rdata_o, m_im_rdata);
            if (m_dm_ack) check("rnd_drd", dm_rdata_o, m_dm_rdata);

            rst_i = ($urandom_range(0, 199) == 0);
            if (im_req_i && m_im_ack) im_req_i = 0;
            else if (im_req_i && $urandom_range(0, 59) == 0) im_req_i = 0;
            else if (!im_req_i && $urandom_range(0, 1) == 0) begin
                im_req_i  = 1;
                im_addr_i = $urandom & 32'hFFFF_FFFC;
            end
            if (dm_req_i && m_dm_ack) dm_req_i = 0;
            else if (dm_req_i && $urandom_range(0, 59) == 0) dm_req_i = 0;
            else if (!dm_req_i && $urandom_range(0, 1) == 0) begin
                dm_req_i   = 1;
                dm_we_i    = $urandom_range(0, 1) == 1;
                dm_addr_i  = $urandom;
                dm_wdata_i = $urandom;
            end
            bus_ack_i   = bus_cyc_o ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
            bus_rdata_i = $urandom;
            @(posedge clk_i);
            model_step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
